// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 7;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, with a configurable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start detect, LSB-first data shift, stop-bit check.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            busy
);

  localparam int unsigned SW = 5;
  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [SW-1:0] MID_CNT  = SW'(MID_TICK);
  localparam logic [SW-1:0] BIT_END  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] STOP_END = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] LAST_BIT = NW'(DBIT - 1);

  logic            rx_s;
  rx_state_t       state, state_n;
  logic [SW-1:0]   s_cnt, s_cnt_n;
  logic [NW-1:0]   n_cnt, n_cnt_n;
  logic [DBIT-1:0] shreg, shreg_n;
  logic [DBIT-1:0] dout_n;
  logic            done_n, frame_err_n;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_rx_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      s_cnt        <= '0;
      n_cnt        <= '0;
      shreg        <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      s_cnt        <= s_cnt_n;
      n_cnt        <= n_cnt_n;
      shreg        <= shreg_n;
      dout         <= dout_n;
      rx_done_tick <= done_n;
      frame_err    <= frame_err_n;
      busy         <= (state_n != IDLE);
    end
  end

  // Next-state logic; everything except the start-edge detect advances on s_tick only.
  always_comb begin
    state_n     = state;
    s_cnt_n     = s_cnt;
    n_cnt_n     = n_cnt;
    shreg_n     = shreg;
    dout_n      = dout;
    frame_err_n = frame_err;
    done_n      = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          s_cnt_n = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt == MID_CNT) begin
            if (!rx_s) begin
              state_n = DATA;
              s_cnt_n = '0;
              n_cnt_n = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_cnt_n = s_cnt + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt == BIT_END) begin
            s_cnt_n = '0;
            shreg_n = {rx_s, shreg[DBIT-1:1]};
            if (n_cnt == LAST_BIT) begin
              state_n = STOP;
            end else begin
              n_cnt_n = n_cnt + NW'(1);
            end
          end else begin
            s_cnt_n = s_cnt + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt == STOP_END) begin
            state_n     = IDLE;
            dout_n      = shreg;
            frame_err_n = ~rx_s;
            done_n      = 1'b1;
          end else begin
            s_cnt_n = s_cnt + SW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
